// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ctrl
// Brief    : Instruction-fetch sequencer: PC owner, in-flight tracking and a
//            2-entry output buffer feeding decode over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_BYTES = 128,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        fault
);

    localparam logic [1:0]  c_ST_IDLE   = 2'd0;
    localparam logic [1:0]  c_ST_RUN    = 2'd1;
    localparam logic [1:0]  c_ST_FAULT  = 2'd2;
    localparam logic [32:0] c_MEM_BYTES = 33'(MEM_BYTES);
    localparam logic [2:0]  c_BUF_DEPTH = 3'(BUF_DEPTH);

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [31:0] r_fetch_pc;
    logic        r_inflight;
    logic [31:0] r_inflight_pc;
    logic        r_head;
    logic [1:0]  r_count;
    logic [31:0] r_buf_pc    [0:1];
    logic [31:0] r_buf_instr [0:1];

    logic [32:0] w_pc_end;
    logic        w_pc_ok;
    logic        w_deq;
    logic        w_capture;
    logic        w_issue;
    logic [2:0]  w_occupancy;
    logic        w_tail;

    // Range check is done one bit wider so a PC near the top of the 32-bit
    // space cannot wrap into the legal window.
    assign w_pc_end    = {1'b0, r_fetch_pc} + 33'd3;
    assign w_pc_ok     = (r_fetch_pc[1:0] == 2'b00) && (w_pc_end < c_MEM_BYTES);
    assign w_deq       = out_valid && out_ready;
    assign w_capture   = r_inflight;
    assign w_occupancy = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_deq};
    assign w_issue     = (r_state == c_ST_RUN) && run_en && w_pc_ok
                         && (w_occupancy < c_BUF_DEPTH) && !redirect_valid;
    // Issue gating keeps count<2 whenever a capture lands, so head+count
    // modulo 2 never points at a live entry.
    assign w_tail      = r_head + r_count[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (redirect_valid) begin
            w_state_next = run_en ? c_ST_RUN : c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (run_en) begin
                        w_state_next = c_ST_RUN;
                    end
                end
                c_ST_RUN: begin
                    if (!run_en) begin
                        w_state_next = c_ST_IDLE;
                    end else if (!w_pc_ok) begin
                        w_state_next = c_ST_FAULT;
                    end
                end
                c_ST_FAULT: begin
                    w_state_next = c_ST_FAULT;
                end
                default: begin
                    w_state_next = c_ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        fault     = (r_state == c_ST_FAULT);
        out_valid = (r_count != 2'd0);
        out_pc    = r_buf_pc[r_head];
        out_instr = r_buf_instr[r_head];
        imem_addr = r_fetch_pc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc     <= RESET_PC;
            r_inflight     <= 1'b0;
            r_inflight_pc  <= 32'h0;
            r_head         <= 1'b0;
            r_count        <= 2'd0;
            r_buf_pc[0]    <= 32'h0;
            r_buf_pc[1]    <= 32'h0;
            r_buf_instr[0] <= 32'h0;
            r_buf_instr[1] <= 32'h0;
        end else if (redirect_valid) begin
            r_fetch_pc <= redirect_pc;
            r_inflight <= 1'b0;
            r_head     <= 1'b0;
            r_count    <= 2'd0;
        end else begin
            if (w_issue) begin
                r_fetch_pc    <= r_fetch_pc + 32'd4;
                r_inflight    <= 1'b1;
                r_inflight_pc <= r_fetch_pc;
            end else begin
                r_inflight <= 1'b0;
            end
            if (w_capture) begin
                r_buf_pc[w_tail]    <= r_inflight_pc;
                r_buf_instr[w_tail] <= imem_instr;
            end
            if (w_deq) begin
                r_head <= ~r_head;
            end
            r_count <= r_count + {1'b0, w_capture} - {1'b0, w_deq};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_ctrl
// Brief    : Scoreboard bench for fetch_ctrl with a registered byte ROM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        run_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fault;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  rom [0:127];
    logic [63:0] q[$];
    logic [63:0] exp_v;

    fetch_ctrl #(
        .RESET_PC (32'h0000_0000),
        .MEM_BYTES(128),
        .BUF_DEPTH(2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .run_en        (run_en),
        .imem_addr     (imem_addr),
        .imem_instr    (imem_instr),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .fault         (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered little-endian ROM read
    always @(posedge clk) begin
        if (imem_addr < 32'd125)
            imem_instr <= {rom[imem_addr[6:0] + 7'd3], rom[imem_addr[6:0] + 7'd2],
                           rom[imem_addr[6:0] + 7'd1], rom[imem_addr[6:0]]};
        else
            imem_instr <= 32'hDEAD_BEEF;
    end

    function automatic logic [63:0] exp_item(input logic [31:0] pc);
        logic [31:0] instr;
        case (pc)
            32'd0:   instr = 32'h0100_0513;
            32'd4:   instr = 32'h02B0_0593;
            32'd8:   instr = 32'h00B5_0633;
            32'd12:  instr = 32'h0000_0013;
            default: instr = 32'hC0DE_0000 | pc;
        endcase
        return {pc, instr};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n          = 1'b0;
        run_en         = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        q.delete();
        tick();
        tick();
    endtask

    task automatic test_reset;
        do_reset();
        checks++;
        if (out_valid !== 1'b0 || fault !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags got valid=%b fault=%b exp 0 0", out_valid, fault);
        end
        checks++;
        if ({imem_addr, out_pc, out_instr} !== 96'h0) begin
            failures++;
            $display("FAIL reset_values got addr=%h pc=%h instr=%h exp all 0", imem_addr, out_pc, out_instr);
        end
    endtask

    // Cycle 0 is the first RUN cycle (the edge after release moves IDLE->RUN).
    task automatic test_stream;
        do_reset();
        for (int i = 0; i < 4; i++) q.push_back(exp_item(32'(i * 4)));
        rst_n = 1'b1; run_en = 1'b1; out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || imem_addr !== 32'd0) begin
            failures++;
            $display("FAIL stream_c0 got valid=%b addr=%h exp 0 00000000", out_valid, imem_addr);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || imem_addr !== 32'd4) begin
            failures++;
            $display("FAIL stream_c1 got valid=%b addr=%h exp 0 00000004", out_valid, imem_addr);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            exp_v = q.pop_front();
            checks++;
            if (out_valid !== 1'b1 || {out_pc, out_instr} !== exp_v) begin
                failures++;
                $display("FAIL stream_out%0d got valid=%b item=%h exp 1 %h", i, out_valid, {out_pc, out_instr}, exp_v);
            end
            tick();
        end
    endtask

    task automatic test_backpressure;
        do_reset();
        for (int i = 0; i < 4; i++) q.push_back(exp_item(32'(i * 4)));
        rst_n = 1'b1; run_en = 1'b1; out_ready = 1'b0;
        repeat (5) tick();
        checks++;
        if (imem_addr !== 32'd8 || out_valid !== 1'b1 || dut.r_count !== 2'd2) begin
            failures++;
            $display("FAIL bp_hold got addr=%h valid=%b count=%0d exp 00000008 1 2", imem_addr, out_valid, dut.r_count);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 20 && q.size() > 0; c++) begin
            if (out_valid && out_ready) begin
                exp_v = q.pop_front();
                checks++;
                if ({out_pc, out_instr} !== exp_v) begin
                    failures++;
                    $display("FAIL bp_order got %h exp %h", {out_pc, out_instr}, exp_v);
                end
            end
            tick();
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL bp_timeout got %0d pending exp 0", q.size());
        end
    endtask

    task automatic test_redirect;
        do_reset();
        q.push_back(exp_item(32'd0));
        q.push_back(exp_item(32'd4));
        rst_n = 1'b1; run_en = 1'b1; out_ready = 1'b1;
        repeat (3) tick();
        for (int i = 0; i < 2; i++) begin
            exp_v = q.pop_front();
            checks++;
            if (out_valid !== 1'b1 || {out_pc, out_instr} !== exp_v) begin
                failures++;
                $display("FAIL redir_pre%0d got valid=%b item=%h exp 1 %h", i, out_valid, {out_pc, out_instr}, exp_v);
            end
            if (i == 0) tick();
        end
        // instr@4 at head and accepted in the redirect cycle
        redirect_valid = 1'b1; redirect_pc = 32'd8;
        q.delete();
        q.push_back(exp_item(32'd8));
        q.push_back(exp_item(32'd12));
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL redir_gap%0d got valid=%b exp 0", i, out_valid);
            end
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            exp_v = q.pop_front();
            checks++;
            if (out_valid !== 1'b1 || {out_pc, out_instr} !== exp_v) begin
                failures++;
                $display("FAIL redir_post%0d got valid=%b item=%h exp 1 %h", i, out_valid, {out_pc, out_instr}, exp_v);
            end
            tick();
        end
    endtask

    task automatic test_misaligned;
        do_reset();
        rst_n = 1'b1; run_en = 1'b1; out_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'd6;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (fault !== 1'b0 || imem_addr !== 32'd6) begin
            failures++;
            $display("FAIL mis_run got fault=%b addr=%h exp 0 00000006", fault, imem_addr);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (fault !== 1'b1 || out_valid !== 1'b0 || imem_addr !== 32'd6) begin
                failures++;
                $display("FAIL mis_fault%0d got fault=%b valid=%b addr=%h exp 1 0 00000006", i, fault, out_valid, imem_addr);
            end
        end
        redirect_valid = 1'b1; redirect_pc = 32'd0;
        q.push_back(exp_item(32'd0));
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (fault !== 1'b0) begin
            failures++;
            $display("FAIL mis_clear got fault=%b exp 0", fault);
        end
        tick();
        tick();
        exp_v = q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || {out_pc, out_instr} !== exp_v) begin
            failures++;
            $display("FAIL mis_recover got valid=%b item=%h exp 1 %h", out_valid, {out_pc, out_instr}, exp_v);
        end
    endtask

    task automatic test_end_of_rom;
        do_reset();
        for (int i = 0; i < 32; i++) q.push_back(exp_item(32'(i * 4)));
        rst_n = 1'b1; run_en = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 60 && q.size() > 0; c++) begin
            if (out_valid && out_ready) begin
                exp_v = q.pop_front();
                checks++;
                if ({out_pc, out_instr} !== exp_v) begin
                    failures++;
                    $display("FAIL eor_order got %h exp %h", {out_pc, out_instr}, exp_v);
                end
            end
            tick();
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL eor_timeout got %0d pending exp 0", q.size());
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b0 || fault !== 1'b1 || imem_addr !== 32'd128) begin
                failures++;
                $display("FAIL eor_stop%0d got valid=%b fault=%b addr=%h exp 0 1 00000080", i, out_valid, fault, imem_addr);
            end
            tick();
        end
    endtask

    task automatic test_stall_reset;
        do_reset();
        rst_n = 1'b1; run_en = 1'b1; out_ready = 1'b0;
        tick();
        tick();
        run_en = 1'b0;
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL sr_stalled got valid=%b exp 1", out_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || fault !== 1'b0 || dut.r_count !== 2'd0 || imem_addr !== 32'd0) begin
            failures++;
            $display("FAIL sr_async got valid=%b fault=%b count=%0d addr=%h exp 0 0 0 00000000", out_valid, fault, dut.r_count, imem_addr);
        end
        tick();
        rst_n = 1'b1; run_en = 1'b1; out_ready = 1'b1;
        q.push_back(exp_item(32'd0));
        q.push_back(exp_item(32'd4));
        repeat (3) tick();
        for (int i = 0; i < 2; i++) begin
            exp_v = q.pop_front();
            checks++;
            if (out_valid !== 1'b1 || {out_pc, out_instr} !== exp_v) begin
                failures++;
                $display("FAIL sr_resume%0d got valid=%b item=%h exp 1 %h", i, out_valid, {out_pc, out_instr}, exp_v);
            end
            tick();
        end
    endtask

    initial begin
        logic [31:0] w;
        rom[0]  = 8'h13; rom[1]  = 8'h05; rom[2]  = 8'h00; rom[3]  = 8'h01;
        rom[4]  = 8'h93; rom[5]  = 8'h05; rom[6]  = 8'hB0; rom[7]  = 8'h02;
        rom[8]  = 8'h33; rom[9]  = 8'h06; rom[10] = 8'hB5; rom[11] = 8'h00;
        rom[12] = 8'h13; rom[13] = 8'h00; rom[14] = 8'h00; rom[15] = 8'h00;
        for (int a = 16; a < 128; a += 4) begin
            w = 32'hC0DE_0000 | 32'(a);
            rom[a]     = w[7:0];
            rom[a + 1] = w[15:8];
            rom[a + 2] = w[23:16];
            rom[a + 3] = w[31:24];
        end
        imem_instr = 32'h0;

        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_misaligned();
        test_end_of_rom();
        test_stall_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
